// File: rtl/sprite_pkg.sv
// Shared sprite geometry and row type for the sprite ROM path.
package sprite_pkg;
  localparam int unsigned SPRITE_W      = 100;
  localparam int unsigned SPRITE_H      = 100;
  localparam int unsigned SPRITE_ADDR_W = 10;
  localparam logic        TRANSPARENT   = 1'b1;

  typedef logic [SPRITE_W-1:0] sprite_row_t;
endpackage

// File: rtl/sprite_row_arbiter_rr_pick.sv
// Combinational round-robin one-hot selector; search starts just after last_id.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_id) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_row_arbiter.sv
// Round-robin arbiter sharing one combinational sprite-row ROM among NUM_REQ
// renderers, with a two-stage registered read pipeline returning tagged rows.
module sprite_row_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = SPRITE_ADDR_W,
  parameter int unsigned ROW_W    = SPRITE_W,
  parameter int unsigned NUM_ROWS = SPRITE_H,
  parameter int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [ROW_W-1:0]          rom_data,
  output logic                      rd_valid,
  output logic [ID_W-1:0]           rd_id,
  output logic [ROW_W-1:0]          rd_data,
  output logic                      rd_err
);

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    last_id;
  logic               transfer;
  logic [ADDR_W-1:0]  win_addr;
  logic               win_oob;

  logic               a_valid;
  logic [ID_W-1:0]    a_id;
  logic               a_oob;
  logic [ADDR_W-1:0]  a_addr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .gnt     (pick_gnt),
    .winner  (winner)
  );

  // Grants are suppressed outright during reset or hold.
  assign gnt      = (Reset || hold) ? '0 : pick_gnt;
  assign transfer = |gnt;
  assign win_addr = req_addr[32'(winner)*ADDR_W +: ADDR_W];
  assign win_oob  = 32'(win_addr) >= NUM_ROWS;
  assign rom_addr = a_addr;

  // Stage A: capture the winning request; out-of-range rows park the ROM at 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_id <= ID_W'(NUM_REQ - 1);
      a_valid <= 1'b0;
      a_id    <= '0;
      a_oob   <= 1'b0;
      a_addr  <= '0;
    end else begin
      a_valid <= transfer;
      if (transfer) begin
        last_id <= winner;
        a_id    <= winner;
        a_oob   <= win_oob;
        a_addr  <= win_oob ? '0 : win_addr;
      end
    end
  end

  // Stage B: register the ROM row, or an all-transparent row on error.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= {ROW_W{TRANSPARENT}};
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= a_valid;
      if (a_valid) begin
        rd_id   <= a_id;
        rd_err  <= a_oob;
        rd_data <= a_oob ? {ROW_W{TRANSPARENT}} : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_row_arbiter.sv
// Directed and randomised checks of the sprite row arbiter with four requesters.
module tb_sprite_row_arbiter;
  import sprite_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned RW = 100;

  logic            clk;
  logic            reset;
  logic            hold;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   gnt;
  logic [AW-1:0]   rom_addr;
  sprite_row_t     rom_data;
  logic            rd_valid;
  logic [1:0]      rd_id;
  sprite_row_t     rd_data;
  logic            rd_err;

  int n_cmp = 0;
  int n_err = 0;

  sprite_row_t ones;
  assign ones = {RW{1'b1}};

  sprite_row_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .ROW_W    (RW),
    .NUM_ROWS (100)
  ) dut (
    .Clk      (clk),
    .Reset    (reset),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_data  (rd_data),
    .rd_err   (rd_err)
  );

  function automatic sprite_row_t rom_row(input logic [AW-1:0] a);
    sprite_row_t r;
    for (int b = 0; b < 100; b++)
      r[7'(b)] = (((int'(a) * 7 + b * 3) % 5) == 0) ^ a[4'(b % 10)];
    return r;
  endfunction

  assign rom_data = rom_row(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    req_addr[i*AW +: AW] = v;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    hold  = 1'b0;
    req   = 4'b1111;
    req_addr = '0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tick();
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_id !== 2'd0) begin n_err++; $display("FAIL reset_rd_id: got %0d want 0", rd_id); end
    n_cmp++; if (rd_data !== ones) begin n_err++; $display("FAIL reset_rd_data: got %h want all ones", rd_data); end
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    req = '0;
  endtask

  task automatic test_single;
    do_reset();
    set_addr(0, 10'd37);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick();
    req = '0;
    n_cmp++; if (rom_addr !== 10'd37) begin n_err++; $display("FAIL single_rom_addr: got %0d want 37", rom_addr); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", rd_valid); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_rd_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rd_id !== 2'd0) begin n_err++; $display("FAIL single_rd_id: got %0d want 0", rd_id); end
    n_cmp++; if (rd_data !== rom_row(10'd37)) begin n_err++; $display("FAIL single_rd_data: got %h want %h", rd_data, rom_row(10'd37)); end
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL single_rd_err: got %b want 0", rd_err); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_pulse: got %b want 0", rd_valid); end
  endtask

  task automatic test_contention;
    logic [3:0]    eg;
    logic [1:0]    eid;
    logic [AW-1:0] ea;
    do_reset();
    set_addr(0, 10'd10);
    set_addr(1, 10'd20);
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      #1;
      eg = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL contend_gnt[%0d]: got %b want %b", i, gnt, eg); end
      tick();
      if (i >= 1) begin
        eid = 2'((i - 1) % 2);
        ea  = (eid == 2'd0) ? 10'd10 : 10'd20;
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL contend_valid[%0d]: got %b want 1", i, rd_valid); end
        n_cmp++; if (rd_id !== eid) begin n_err++; $display("FAIL contend_id[%0d]: got %0d want %0d", i, rd_id, eid); end
        n_cmp++; if (rd_data !== rom_row(ea)) begin n_err++; $display("FAIL contend_data[%0d]: got %h want %h", i, rd_data, rom_row(ea)); end
      end
    end
    req = '0;
  endtask

  task automatic test_oob;
    do_reset();
    set_addr(1, 10'd100);
    req = 4'b0010;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL oob_gnt: got %b want 0010", gnt); end
    tick();
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL oob_rom_addr100: got %0d want 0", rom_addr); end
    set_addr(1, 10'd1023);
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL oob_b2b_gnt: got %b want 0010", gnt); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL oob_valid100: got %b want 1", rd_valid); end
    n_cmp++; if (rd_id !== 2'd1) begin n_err++; $display("FAIL oob_id100: got %0d want 1", rd_id); end
    n_cmp++; if (rd_err !== 1'b1) begin n_err++; $display("FAIL oob_err100: got %b want 1", rd_err); end
    n_cmp++; if (rd_data !== ones) begin n_err++; $display("FAIL oob_data100: got %h want all ones", rd_data); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL oob_rom_addr1023: got %0d want 0", rom_addr); end
    set_addr(1, 10'd99);
    tick();
    req = '0;
    n_cmp++; if (rd_err !== 1'b1) begin n_err++; $display("FAIL oob_err1023: got %b want 1", rd_err); end
    n_cmp++; if (rd_data !== ones) begin n_err++; $display("FAIL oob_data1023: got %h want all ones", rd_data); end
    n_cmp++; if (rom_addr !== 10'd99) begin n_err++; $display("FAIL oob_rom_addr99: got %0d want 99", rom_addr); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL oob_valid99: got %b want 1", rd_valid); end
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL oob_err99: got %b want 0", rd_err); end
    n_cmp++; if (rd_data !== rom_row(10'd99)) begin n_err++; $display("FAIL oob_data99: got %h want %h", rd_data, rom_row(10'd99)); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL oob_idle: got %b want 0", rd_valid); end
  endtask

  task automatic test_hold;
    do_reset();
    set_addr(0, 10'd5);
    set_addr(1, 10'd6);
    hold = 1'b1;
    req  = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL hold_gnt[%0d]: got %b want 0000", i, gnt); end
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 0", i, rd_valid); end
    end
    hold = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL hold_release_gnt: got %b want 0001", gnt); end
    tick();
    req  = 4'b0010;
    hold = 1'b1;
    n_cmp++; if (rom_addr !== 10'd5) begin n_err++; $display("FAIL hold_rom_addr: got %0d want 5", rom_addr); end
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL hold_mid_gnt: got %b want 0000", gnt); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL hold_drain_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== rom_row(10'd5)) begin n_err++; $display("FAIL hold_drain_data: got %h want %h", rd_data, rom_row(10'd5)); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL hold_drain_end: got %b want 0", rd_valid); end
    hold = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL hold_resume_gnt: got %b want 0010", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_addr(2, 10'd200);
    req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL rmid_gnt2: got %b want 0100", gnt); end
    tick();
    set_addr(0, 10'd42);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmid_gnt0: got %b want 0001", gnt); end
    tick();
    n_cmp++; if (rom_addr !== 10'd42) begin n_err++; $display("FAIL rmid_rom_addr: got %0d want 42", rom_addr); end
    n_cmp++; if (rd_id !== 2'd2 || rd_err !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got id %0d err %b want id 2 err 1", rd_id, rd_err); end
    reset = 1'b1;
    req   = '0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rmid_gnt_reset: got %b want 0000", gnt); end
    tick();
    reset = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_id !== 2'd0) begin n_err++; $display("FAIL rmid_id: got %0d want 0", rd_id); end
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b want 0", rd_err); end
    n_cmp++; if (rd_data !== ones) begin n_err++; $display("FAIL rmid_data: got %h want all ones", rd_data); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL rmid_rom_addr0: got %0d want 0", rom_addr); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_discard: got %b want 0", rd_valid); end
    req = 4'b1001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmid_last_id: got %b want 0001", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_fairness;
    int            wait_cnt[NR];
    logic [AW-1:0] addrs[NR];
    logic [1:0]    m_last, w, ma_id, mb_id;
    logic          ma_v, mb_v;
    logic [AW-1:0] ma_addr, mb_addr, na;
    logic [3:0]    eg;
    sprite_row_t   ed;
    int            idx;
    do_reset();
    m_last = 2'd3; ma_v = 1'b0; mb_v = 1'b0;
    ma_id = '0; mb_id = '0; ma_addr = '0; mb_addr = '0; w = '0;
    for (int i = 0; i < int'(NR); i++) begin wait_cnt[i] = 0; addrs[i] = '0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      n_cmp++; if (rd_valid !== mb_v) begin n_err++; $display("FAIL fair_valid@%0d: got %b want %b", cyc, rd_valid, mb_v); end
      else if (mb_v) begin
        ed = (mb_addr >= 10'd100) ? ones : rom_row(mb_addr);
        n_cmp++; if (rd_id !== mb_id) begin n_err++; $display("FAIL fair_id@%0d: got %0d want %0d", cyc, rd_id, mb_id); end
        n_cmp++; if (rd_err !== (mb_addr >= 10'd100)) begin n_err++; $display("FAIL fair_err@%0d: got %b want %b", cyc, rd_err, mb_addr >= 10'd100); end
        n_cmp++; if (rd_data !== ed) begin n_err++; $display("FAIL fair_data@%0d: got %h want %h", cyc, rd_data, ed); end
      end
      for (int i = 0; i < int'(NR); i++) begin
        if (!req[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            na = 10'($urandom_range(127, 0));
            req[i] = 1'b1; set_addr(i, na); addrs[i] = na; wait_cnt[i] = 0;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          req[i] = 1'b0; wait_cnt[i] = 0;
        end
      end
      hold = ($urandom_range(7, 0) == 0);
      #1;
      eg = '0;
      if (!hold) begin
        for (int k = 1; k <= int'(NR); k++) begin
          idx = (int'(m_last) + k) % int'(NR);
          if (eg == 4'b0000 && req[2'(idx)]) begin eg[2'(idx)] = 1'b1; w = 2'(idx); end
        end
      end
      n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL fair_gnt@%0d: got %b want %b", cyc, gnt, eg); end
      mb_v = ma_v; mb_id = ma_id; mb_addr = ma_addr;
      ma_v = (eg != 4'b0000);
      if (ma_v) begin ma_id = w; ma_addr = addrs[w]; m_last = w; end
      if (ma_v) begin
        for (int i = 0; i < int'(NR); i++) begin
          if (req[i] && !eg[i]) begin
            wait_cnt[i]++;
            n_cmp++; if (wait_cnt[i] > int'(NR) - 1) begin n_err++; $display("FAIL fair_wait@%0d: req %0d waited %0d want <= %0d", cyc, i, wait_cnt[i], NR - 1); end
          end
        end
      end
      tick();
      if (eg != 4'b0000) begin req[w] = 1'b0; wait_cnt[w] = 0; end
    end
    req  = '0;
    hold = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req = '0; req_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_oob();
    test_hold();
    test_reset_mid();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_row_arbiter.md
Name: sprite_row_arbiter

Overview:
- Round-robin arbiter and two-stage read pipeline that shares one combinational 1-bit sprite row ROM among NUM_REQ renderers, e.g. player-1 and player-2 projectile draw engines.
- Each requester supplies a row address. The block returns the full registered row with a requester tag two edges after acceptance.
- It sits between the per-sprite draw logic and the sprite ROM, inside the VGA colour-mapping path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 10, ROM row-address width.
- ROW_W, 100, bits per ROM row (sprite width).
- NUM_ROWS, 100, valid rows; addresses at or above this are out of range.
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester tag.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no request is granted.
- req  in  NUM_REQ  per-requester request; held until granted.
- req_addr  in  NUM_REQ*ADDR_W  flattened row addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot combinational grant.
- rom_addr  out  ADDR_W  address driven to the sprite ROM.
- rom_data  in  ROW_W  ROM row; combinational in rom_addr.
- rd_valid  out  1  rd_data/rd_id/rd_err valid this cycle.
- rd_id  out  ID_W  requester index of the returned row.
- rd_data  out  ROW_W  returned row; bit 0 = leftmost pixel; 1 = transparent, 0 = sprite pixel.
- rd_err  out  1  returned request was out of range.

Behaviour:
- Handshake:
  - Transfer occurs on a rising edge where req[i] & gnt[i].
  - gnt is at most one-hot. gnt = 0 while Reset or hold is 1.
  - Requesters hold req and req_addr stable until the edge on which they are granted.
  - A requester may drop req without a grant; there is no penalty.
- Arbitration: round-robin pointer last_id (reset to NUM_REQ-1).
  - Priority order is last_id+1, last_id+2, ... modulo NUM_REQ.
  - The first asserting requester in that order wins.
  - last_id updates to the winner on each transfer and is unchanged otherwise.
  - With every requester continuously asserting, grants rotate 0,1,...,NUM_REQ-1,0,...
  - One transfer per cycle at most; a requester re-asserting immediately is granted back-to-back if alone.
- Stage A, registered on the transfer edge:
  - a_valid <= transfer; a_id <= winner; a_oob <= (req_addr[winner] >= NUM_ROWS).
  - a_addr <= req_addr[winner], or 0 if out of range.
  - No transfer: a_valid <= 0, other A registers hold.
  - rom_addr = a_addr (registered, glitch-free into the ROM).
- Stage B, every edge:
  - rd_valid <= a_valid.
  - If a_valid: rd_id <= a_id; rd_err <= a_oob; rd_data <= a_oob ? all ones : rom_data.
  - Otherwise rd_id, rd_data and rd_err hold.
- Latency and throughput:
  - Grant at edge k gives rd_valid high for exactly the cycle after edge k+2 (two edges).
  - Full throughput is one row per cycle, with no backpressure; consumers must accept rd_* when rd_valid.
- hold asserted mid-stream: already-accepted reads still complete (stage A/B drain); no new grants.
- Reset values:
  - gnt 0; last_id NUM_REQ-1.
  - a_valid 0; a_addr 0, so rom_addr 0.
  - rd_valid 0, rd_id 0, rd_data all ones, rd_err 0.
- Reset mid-operation: in-flight reads are discarded (no rd_valid is produced for them); requesters must re-request.
- Address arithmetic: unsigned compare; no wrap-around. Addresses 100..1023 all flag rd_err.

Decomposition:
- Shared package sprite_pkg holds:
  - constants SPRITE_W=100, SPRITE_H=100, SPRITE_ADDR_W=10;
  - localparam TRANSPARENT = 1'b1;
  - typedef sprite_row_t = logic [SPRITE_W-1:0].
- One sub-module is natural: rr_pick, a combinational round-robin one-hot selector (inputs: req vector, last_id; outputs: one-hot gnt, winner index).
- The pipeline registers stay in the top.

Test Plan:
- Single request: after Reset, req=01, addr0=37 -> gnt=01 that cycle; rom_addr=37 next cycle; rd_valid=1, rd_id=0, rd_data=ROM[37] one cycle later, rd_err=0.
- Contention: req=11 held continuously, addr0=10, addr1=20 -> grants alternate 01,10,01,10. Back-to-back rd_valid shows ids 0,1,0,1 with rows 10,20,10,20.
- Out of range: addr1=100, then addr1=1023 -> rd_err=1 and rd_data all ones both times; rom_addr=0 for those cycles.
- hold: req=11 with hold=1 for 5 cycles -> gnt=00 and no rd_valid. On release, requester 0 is granted first (last_id=1 from reset).
- Pipeline drain and reset:
  - hold rises the cycle after a grant -> that read still returns rd_valid.
  - Reset asserted the cycle after a grant -> no rd_valid follows.
  - All outputs and last_id take their reset values at the next edge.
- Fairness: 4 requesters, NUM_REQ=4, random req patterns for 10k cycles:
  - no requester waits more than NUM_REQ-1 transfers while asserting;
  - every returned row matches a model ROM for its tagged address.
